// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared restoring divider.
// One quotient bit per clock; result, owner id and divide-by-zero flag held until the next done.
module div_arbiter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            last_grant_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] r_reg;

    logic             any_req;
    logic             winner;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] dvd_next;
    logic             last_iter;

    // Both requesting: the one not granted last wins; otherwise the lone requester.
    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ~last_grant_reg : req1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign sel_a[gi] = winner ? a1[gi] : a0[gi];
            assign sel_b[gi] = winner ? b1[gi] : b0[gi];
        end
    endgenerate

    // The shifted partial remainder is WIDTH+1 bits wide so dividends with the MSB set
    // still divide correctly; when its top bit is set it always exceeds the divisor, and
    // the true difference is below the divisor, so a WIDTH-bit subtract is exact.
    assign r_shift   = {r_reg, dvd_reg[WIDTH-1]};
    assign fits      = r_shift[WIDTH] | (r_shift[WIDTH-1:0] >= dvs_reg);
    assign r_next    = fits ? (r_shift[WIDTH-1:0] - dvs_reg) : r_shift[WIDTH-1:0];
    // Quotient bits shift into the low end of the dividend register as its bits are consumed.
    assign dvd_next  = {dvd_reg[WIDTH-2:0], fits};
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            dvd_reg        <= '0;
            dvs_reg        <= '0;
            r_reg          <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            done_id        <= 1'b0;
            quo            <= '0;
            rem            <= '0;
            dbz            <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        dvd_reg        <= sel_a;
                        dvs_reg        <= sel_b;
                        r_reg          <= '0;
                        cnt_reg        <= '0;
                        last_grant_reg <= winner;
                        ack0           <= ~winner;
                        ack1           <= winner;
                        busy           <= 1'b1;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    r_reg   <= r_next;
                    dvd_reg <= dvd_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        quo       <= dvd_next;
                        rem       <= r_next;
                        dbz       <= (dvs_reg == '0);
                        done      <= 1'b1;
                        done_id   <= last_grant_reg;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table plus arbitration, reset and throughput sequences.
// Expected results are queued when requests are driven and compared when done strobes.
module tb_div_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0, req1;
    logic [9:0] a0, b0, a1, b1;
    logic       ack0, ack1, busy, done, done_id, dbz;
    logic [9:0] quo, rem;

    div_arbiter #(.WIDTH(10)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .done(done), .done_id(done_id),
        .quo(quo), .rem(rem), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [9:0] q;
        logic [9:0] r;
        bit         z;
    } exp_t;

    typedef struct {
        bit         id;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q;
        logic [9:0] r;
        bit         z;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_ack = -100;
    int last_done = -1;
    bit chk_spacing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor: protocol checks every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        if (rstn) begin
            if (ack0 | ack1) last_ack = cyc;
            if (ack0 & ack1) check("ack_exclusive", 1, 0);
            if (done & (ack0 | ack1)) check("done_ack_overlap", 1, 0);
            if (done) begin
                $display("txn done_id=%0d quo=%0d rem=%0d dbz=%0d cycle=%0d", done_id, quo, rem, dbz, cyc);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_id", done_id, mon_e.id);
                    check("quo", quo, mon_e.q);
                    check("rem", rem, mon_e.r);
                    check("dbz", dbz, mon_e.z);
                    check("latency", cyc - last_ack, 10);
                    if (chk_spacing && last_done >= 0) check("done_spacing", cyc - last_done, 11);
                end
                last_done = cyc;
            end
        end
    end

    task automatic push(input bit id, input logic [9:0] q, input logic [9:0] r, input bit z);
        exp_t e;
        e.id = id; e.q = q; e.r = r; e.z = z;
        sb.push_back(e);
    endtask

    task automatic request(input bit id, input logic [9:0] a, input logic [9:0] b);
        bit got = 1'b0;
        @(negedge clk);
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = id ? ack1 : ack0;
        end
        if (!got) check("ack_timeout", 0, 1);
        check("busy_after_ack", busy, 1);
        // Operands change right after the grant; the divider must already have them.
        if (id) begin req1 = 1'b0; a1 = ~a; b1 = ~b; end
        else    begin req0 = 1'b0; a0 = ~a; b0 = ~b; end
        @(negedge clk);
        check("ack_one_cycle", id ? ack1 : ack0, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit got;

        vecs[0] = '{1'b0, 10'd23,   10'd6,    10'd3,    10'd5,   1'b0};
        vecs[1] = '{1'b1, 10'd1023, 10'd1,    10'd1023, 10'd0,   1'b0};
        vecs[2] = '{1'b1, 10'd1000, 10'd999,  10'd1,    10'd1,   1'b0};
        vecs[3] = '{1'b0, 10'd100,  10'd0,    10'd1023, 10'd100, 1'b1};
        vecs[4] = '{1'b0, 10'd9,    10'd3,    10'd3,    10'd0,   1'b0};
        vecs[5] = '{1'b1, 10'd512,  10'd2,    10'd256,  10'd0,   1'b0};
        vecs[6] = '{1'b0, 10'd1023, 10'd1023, 10'd1,    10'd0,   1'b0};
        vecs[7] = '{1'b1, 10'd5,    10'd7,    10'd0,    10'd5,   1'b0};
        vecs[8] = '{1'b0, 10'd0,    10'd0,    10'd1023, 10'd0,   1'b1};
        vecs[9] = '{1'b1, 10'd777,  10'd25,   10'd31,   10'd2,   1'b0};

        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ack0", ack0, 0);  check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);  check("rst_done", done, 0);
        check("rst_quo", quo, 0);    check("rst_rem", rem, 0);
        check("rst_dbz", dbz, 0);    check("rst_done_id", done_id, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            push(vecs[i].id, vecs[i].q, vecs[i].r, vecs[i].z);
            request(vecs[i].id, vecs[i].a, vecs[i].b);
            wait_done();
        end

        // Simultaneous requests after a requester-1 grant: 0 first, then 1.
        push(1'b0, 10'd8, 10'd1, 1'b0);
        push(1'b1, 10'd9, 10'd2, 1'b0);
        fork
            request(1'b0, 10'd73, 10'd9);
            request(1'b1, 10'd65, 10'd7);
        join
        wait_done();

        // Continuous requests from both: strict alternation, 11-clock throughput.
        for (int i = 0; i < 4; i++) push(i[0], 10'd3, 10'd0, 1'b0);
        @(negedge clk);
        a0 = 10'd15; b0 = 10'd5; a1 = 10'd15; b1 = 10'd5;
        req0 = 1'b1; req1 = 1'b1;
        last_done = -1;
        chk_spacing = 1'b1;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                check("alt_grant", ack1, n % 2);
                n++;
                if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        if (n != 4) begin
            check("alt_grant_count", n, 4);
            req0 = 1'b0; req1 = 1'b0;
        end
        wait_done();
        chk_spacing = 1'b0;

        // Reset mid-division: nothing completes, held request is re-granted afterwards.
        @(negedge clk);
        a0 = 10'd100; b0 = 10'd7; req0 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ack0;
        end
        if (!got) check("rst_seq_ack", 0, 1);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);   check("mid_rst_done", done, 0);
        check("mid_rst_quo", quo, 0);     check("mid_rst_rem", rem, 0);
        check("mid_rst_dbz", dbz, 0);     check("mid_rst_done_id", done_id, 0);
        check("mid_rst_ack0", ack0, 0);   check("mid_rst_ack1", ack1, 0);
        @(negedge clk);
        rstn = 1'b1;
        push(1'b0, 10'd14, 10'd2, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ack0;
        end
        if (!got) check("rst_reack", 0, 1);
        req0 = 1'b0;
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
